aes_byte_feeder: RTL



---
 rtl/aes_feeder_pkg.sv | 19 +
 rtl/aes_feeder_shreg.sv | 29 ++
 rtl/aes_byte_feeder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/aes_feeder_pkg.sv
// Shared types and constants for the AES byte feeder.
package aes_feeder_pkg;

  localparam int unsigned BLK_BYTES = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BLK_W     = BLK_BYTES * BYTE_W;
  localparam int unsigned WD_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    LOAD,
    WAIT,
    SKIP,
    COLL,
    HOLD
  } feeder_state_t;

endpackage

// File: rtl/aes_feeder_shreg.sv
// 128-bit loadable register that shifts left one byte per enabled cycle.
// byte_out is the top byte; byte_in enters at the bottom. Load wins over shift.
import aes_feeder_pkg::*;

module aes_feeder_shreg (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BLK_W-1:0]  load_val,
  input  logic              shift,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [BLK_W-1:0]  q,
  output logic [BYTE_W-1:0] byte_out
);

  // Load, or shift one byte towards the MSB end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[BLK_W-BYTE_W-1:0], byte_in};
    end
  end

  assign byte_out = q[BLK_W-1 -: BYTE_W];

endmodule

// File: rtl/aes_byte_feeder.sv
// Feeds one key/plaintext pair byte-wise into the 8-bit serial AES core and
// gathers the 16 ciphertext bytes into a 128-bit result.
// Optional: AES_FEEDER_TIMEOUT_EN adds a WAIT watchdog and an err output.
import aes_feeder_pkg::*;

module aes_byte_feeder #(
  parameter int unsigned CRST_CYC = 2,
  parameter int unsigned CAP_DLY  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         core_rst,
  output logic [7:0]   core_key,
  output logic [7:0]   core_din,
  input  logic [7:0]   core_dout,
  input  logic         core_data_valid
`ifdef AES_FEEDER_TIMEOUT_EN
  ,
  output logic         err
`endif
);

  feeder_state_t     state, nstate;
  logic [3:0]        cnt, ncnt;
  logic              accept;
  logic              timeout;
  logic              wd_expired;
  logic [BYTE_W-1:0] key_byte, din_byte, dout_q;
  logic [BLK_W-1:0]  unused_key_q, unused_din_q;
  logic [BYTE_W-1:0] unused_res_byte;

  aes_feeder_shreg u_key_sh (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (in_key),
    .shift    (nstate == LOAD),
    .byte_in  ('0),
    .q        (unused_key_q),
    .byte_out (key_byte)
  );

  aes_feeder_shreg u_din_sh (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (in_data),
    .shift    (nstate == LOAD),
    .byte_in  ('0),
    .q        (unused_din_q),
    .byte_out (din_byte)
  );

  // Cleared on acceptance so no byte of a previous result survives; a
  // watchdog expiry also clears it so HOLD presents zero.
  aes_feeder_shreg u_res_sh (
    .clk      (clk),
    .rst      (rst),
    .load     (accept || timeout),
    .load_val ('0),
    .shift    (state == COLL),
    .byte_in  (dout_q),
    .q        (out_data),
    .byte_out (unused_res_byte)
  );

`ifdef AES_FEEDER_TIMEOUT_EN
  logic [WD_W-1:0] wd;

  // Watchdog counts consecutive WAIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                wd <= '0;
    else if (state == WAIT)  wd <= wd + 1'b1;
    else                     wd <= '0;
  end

  // Error flag set on expiry, cleared when the result handshake completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             err <= 1'b0;
    else if (timeout)                     err <= 1'b1;
    else if (state == HOLD && out_ready)  err <= 1'b0;
  end

  assign wd_expired = (wd == '1);
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state and counter logic.
  // core_dout is registered into dout_q, so COLL consumes the byte that was on
  // the bus one cycle earlier: with CAP_DLY = 0 the byte seen alongside
  // core_data_valid in WAIT is the first one captured, and SKIP lasting
  // CAP_DLY cycles lines COLL up with the first valid byte.
  always_comb begin
    nstate  = state;
    ncnt    = cnt;
    accept  = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept = 1'b1;
          nstate = CRST;
          ncnt   = 4'(CRST_CYC - 1);
        end
      end
      CRST: begin
        if (cnt == '0) begin
          nstate = LOAD;
          ncnt   = '0;
        end else begin
          ncnt = cnt - 4'd1;
        end
      end
      LOAD: begin
        ncnt = cnt + 4'd1;
        if (cnt == 4'(BLK_BYTES - 1)) nstate = WAIT;
      end
      WAIT: begin
        if (core_data_valid) begin
          if (CAP_DLY > 0) begin
            nstate = SKIP;
            ncnt   = 4'(CAP_DLY - 1);
          end else begin
            nstate = COLL;
            ncnt   = '0;
          end
        end else if (wd_expired) begin
          nstate  = HOLD;
          timeout = 1'b1;
        end
      end
      SKIP: begin
        if (cnt == '0) begin
          nstate = COLL;
          ncnt   = '0;
        end else begin
          ncnt = cnt - 4'd1;
        end
      end
      COLL: begin
        ncnt = cnt + 4'd1;
        if (cnt == 4'(BLK_BYTES - 1)) nstate = HOLD;
      end
      HOLD: begin
        if (out_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // State register plus flopped outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      core_rst  <= 1'b1;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      core_key  <= '0;
      core_din  <= '0;
      dout_q    <= '0;
    end else begin
      state     <= nstate;
      cnt       <= ncnt;
      core_rst  <= (nstate == IDLE) || (nstate == CRST) || (nstate == HOLD);
      in_ready  <= (nstate == IDLE);
      busy      <= (nstate != IDLE);
      out_valid <= (nstate == HOLD);
      core_key  <= (nstate == LOAD) ? key_byte : '0;
      core_din  <= (nstate == LOAD) ? din_byte : '0;
      dout_q    <= core_dout;
    end
  end

endmodule
